cell16_mem_seq: RTL and testbench
=================================

// Module: cell16_mem_seq
// PURPOSE
//  Upstream master for the 8-bit single-port RAM (128K x 8, 17-bit byte address).
//  Turns eForth1 16-bit cell and byte accesses (@ ! C@ C!) into sequenced byte
//  transactions on the RAM port.
//  Cells are big-endian: high byte at addr, low byte at addr+1.
//  Sits between the eForth1 core/bus and spram8_128k; one request in flight.
// PARAMETERS
//  ASZ     17  byte address width (128K)
//  DSZ     8   RAM data width
//  RD_LAT  1   RAM read latency: cycles from address valid to mem_vo valid (0..3)
// PORTS
//  clk        in   1    system clock, all state on posedge
//  rst_n      in   1    asynchronous active-low reset
//  req_valid  in   1    request present; held stable by master until accepted
//  req_ready  out  1    block can accept; transfer = req_valid & req_ready at posedge
//  req_we     in   1    1=write, 0=read
//  req_byte   in   1    1=byte access (C@/C!), 0=16-bit cell
//  req_addr   in   ASZ  byte address of the access
//  req_wdata  in   16   write data; byte access uses [7:0]
//  rsp_valid  out  1    one-cycle pulse: access complete (reads and writes)
//  rsp_rdata  out  16   read data, valid with rsp_valid; byte read = {8'h00, byte}
//  mem_ai     out  ASZ  RAM byte address
//  mem_vi     out  DSZ  RAM write data
//  mem_we     out  1    RAM write enable
//  mem_vo     in   DSZ  RAM read data
// BEHAVIOUR
//  Reset (async assert): state=IDLE; req_ready=0; rsp_valid=0; rsp_rdata=0;
//   mem_we=0; mem_ai=0; mem_vi=0.
//   req_ready rises on the first posedge after rst_n release.
//  FSM states: IDLE -> {WR0, RD0} -> {WR1, RD1} -> RSP -> IDLE.
//   Byte accesses skip WR1/RD1.
//  IDLE: req_ready=1; on transfer latch we/byte/addr/wdata, drop req_ready, go WR0|RD0.
//  WR0: mem_ai=addr, mem_we=1, mem_vi = byte ? wdata[7:0] : wdata[15:8]; 1 cycle.
//  WR1: mem_ai=addr+1, mem_we=1, mem_vi=wdata[7:0]; 1 cycle.
//  RD0/RD1: mem_we=0; mem_ai=addr (RD0) or addr+1 (RD1); each held RD_LAT+1 cycles.
//   Down-counter counts the hold; mem_vo sampled on the last posedge of the phase.
//   RD0 sample -> rdata[15:8] (cell) or rdata[7:0] with [15:8]=0 (byte).
//   RD1 sample -> rdata[7:0].
//  RSP: rsp_valid=1 for exactly one cycle, mem_we=0, rsp_rdata stable;
//   next cycle IDLE with req_ready=1.
//   rsp_rdata holds its value until the next read completes.
//  Latency from accept edge to rsp_valid cycle:
//   cell write 3; byte write 2; cell read 2*(RD_LAT+1)+1; byte read (RD_LAT+1)+1.
//  Back-to-back: a new request can be accepted the cycle after RSP; no overlap.
//  Address arithmetic: addr+1 is modulo 2^ASZ, so 17'h1FFFF wraps to 17'h00000.
//   No alignment requirement; odd addresses are legal.
//  mem_we is driven only in WR0/WR1 and is 0 in every other state, including the RSP cycle.
//  req_valid while req_ready=0 is ignored (no latch, no error).
//  Inputs change during a transaction: no effect, operands are latched at accept.
//  Reset mid-transaction: abort immediately, mem_we drops asynchronously, no rsp_valid.
//   A write may leave one byte updated.
// STRUCTURE
//  Package eforth_mem_pkg:
//   addr_t = logic [ASZ-1:0]; cell_t = logic [15:0];
//   typedef enum {IDLE, WR0, WR1, RD0, RD1, RSP} mseq_st_e.
//  Single always_ff for state/latches/counter; always_comb for mem_* drive.
//  No sub-module: the byte sequencing is one FSM.
// TESTING (bench instantiates spram8_128k behind this block, RD_LAT=1)
//  1 cell write 16'hA55A @17'h00010, then cell read -> rsp_rdata=16'hA55A;
//    raw RAM[0x10]=8'hA5, RAM[0x11]=8'h5A.
//  2 byte write 8'h3C @17'h00021, byte read -> 16'h003C;
//    cell read @17'h00020 -> {RAM[0x20], 8'h3C}.
//  3 cell write 16'h1234 @17'h1FFFF -> RAM[0x1FFFF]=8'h12, RAM[0x00000]=8'h34;
//    cell read returns 16'h1234.
//  4 latency: cell read accept to rsp_valid = 5 cycles, cell write = 3 cycles;
//    req_ready=0 throughout; rsp_valid high exactly one cycle.
//  5 req_valid held high with changing addr/wdata during a write:
//    only the accepted operands are written; next request is accepted the cycle after RSP.
//  6 rst_n pulsed low mid cell-write (during WR1):
//    mem_we=0 and rsp_valid=0 at once; req_ready=1 one edge after release;
//    a following read completes normally.

Source files
------------

// File: rtl/eforth_mem_pkg.sv
// Shared types for the eForth1 memory sequencer: address/cell types, FSM states, latched request.
// Latency: n/a (types only).
// Backpressure: n/a.
package eforth_mem_pkg;

  localparam int ASZ = 17;  // byte address width (128K)
  localparam int DSZ = 8;   // RAM data width

  typedef logic [ASZ-1:0] addr_t;
  typedef logic [15:0]    cell_t;
  typedef logic [DSZ-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    WR1  = 3'd2,
    RD0  = 3'd3,
    RD1  = 3'd4,
    RSP  = 3'd5
  } mseq_st_e;

  // Operands captured at accept; the requester may change its inputs afterwards.
  typedef struct packed {
    logic  we;
    logic  byt;
    addr_t addr;
    cell_t wdata;
  } mreq_t;

endpackage

// File: rtl/spram8_128k.sv
// Single-port 128K x 8 RAM, synchronous write, registered read data.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; accepts an access every cycle.
// Ports: clk; ai byte address; vi write data; we write enable; vo read data.
module spram8_128k
  import eforth_mem_pkg::*;
(
  input  logic  clk,
  input  addr_t ai,
  input  byte_t vi,
  input  logic  we,
  output byte_t vo
);

  byte_t mem [0:(1<<ASZ)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[ai] <= vi;
    end
    vo <= mem[ai];
  end

endmodule

// File: rtl/cell16_mem_seq.sv
// Turns 16-bit big-endian cell and byte accesses into sequenced byte accesses on an 8-bit RAM.
// Latency (accept to rsp_valid cycle): cell wr 3, byte wr 2, cell rd 2*(RD_LAT+1)+1, byte rd RD_LAT+2.
// Backpressure: req_ready only in IDLE; one request in flight, next accept the cycle after RSP.
// Ports: clk, rst_n; req_valid/req_ready/req_we/req_byte/req_addr/req_wdata request side;
//        rsp_valid/rsp_rdata completion; mem_ai/mem_vi/mem_we/mem_vo RAM side.
module cell16_mem_seq
  import eforth_mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req_valid,
  output logic  req_ready,
  input  logic  req_we,
  input  logic  req_byte,
  input  addr_t req_addr,
  input  cell_t req_wdata,
  output logic  rsp_valid,
  output cell_t rsp_rdata,
  output addr_t mem_ai,
  output byte_t mem_vi,
  output logic  mem_we,
  input  byte_t mem_vo
);

  mseq_st_e   state, nxt;
  mreq_t      req_q;
  logic       alive;     // holds req_ready low until the first edge after reset release
  logic [1:0] cnt;       // remaining hold cycles of the current read phase
  byte_t      rd_hi;     // high byte of a cell read, kept until the low byte arrives
  addr_t      addr_p1;
  logic       accept;

  // Second byte of a cell wraps modulo 2^ASZ.
  assign addr_p1 = req_q.addr + addr_t'(1);
  assign accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alive     <= 1'b0;
      req_q     <= '0;
      cnt       <= '0;
      rd_hi     <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= nxt;
      alive <= 1'b1;
      if (accept) begin
        req_q <= '{we: req_we, byt: req_byte, addr: req_addr, wdata: req_wdata};
      end
      // Each read phase holds its address RD_LAT+1 cycles; sample on the last one.
      if ((nxt == RD0 || nxt == RD1) && nxt != state) begin
        cnt <= 2'(RD_LAT);
      end else if (cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
      if (state == RD0 && cnt == 2'd0) begin
        if (req_q.byt) begin
          rsp_rdata <= {8'h00, mem_vo};
        end else begin
          rd_hi <= mem_vo;
        end
      end
      // rsp_rdata only updates once the whole cell is in, so it never shows a half value.
      if (state == RD1 && cnt == 2'd0) begin
        rsp_rdata <= {rd_hi, mem_vo};
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = req_we ? WR0 : RD0;
      WR0:  nxt = req_q.byt ? RSP : WR1;
      WR1:  nxt = RSP;
      RD0:  if (cnt == 2'd0) nxt = req_q.byt ? RSP : RD1;
      RD1:  if (cnt == 2'd0) nxt = RSP;
      RSP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ai    = '0;
    mem_vi    = '0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    req_ready = alive && (state == IDLE);
    unique case (state)
      WR0: begin
        mem_ai = req_q.addr;
        mem_we = 1'b1;
        mem_vi = req_q.byt ? req_q.wdata[7:0] : req_q.wdata[15:8];
      end
      WR1: begin
        mem_ai = addr_p1;
        mem_we = 1'b1;
        mem_vi = req_q.wdata[7:0];
      end
      RD0:  mem_ai = req_q.addr;
      RD1:  mem_ai = addr_p1;
      RSP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cell16_mem_seq.sv
// Directed bench: cell16_mem_seq driving spram8_128k with RD_LAT=1.
// Latency: n/a.
// Backpressure: requests wait for req_ready before the accept edge.
module tb_cell16_mem_seq;
  import eforth_mem_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  req_valid = 1'b0;
  logic  req_ready;
  logic  req_we = 1'b0;
  logic  req_byte = 1'b0;
  addr_t req_addr = '0;
  cell_t req_wdata = '0;
  logic  rsp_valid;
  cell_t rsp_rdata;
  addr_t mem_ai;
  byte_t mem_vi;
  logic  mem_we;
  byte_t mem_vo;

  cell16_mem_seq #(.RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_ai(mem_ai), .mem_vi(mem_vi), .mem_we(mem_we), .mem_vo(mem_vo)
  );

  spram8_128k u_ram (.clk(clk), .ai(mem_ai), .vi(mem_vi), .we(mem_we), .vo(mem_vo));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Observations from the last xfer call.
  int   busy_rdy;   // cycles where req_ready was high while busy
  logic rsp_long;   // rsp_valid still high the cycle after the pulse
  logic rdy_after;  // req_ready the cycle after the pulse

  // One request, inputs dropped right after accept; returns read data and latency in cycles.
  task automatic xfer(input logic we, input logic byt, input addr_t a, input cell_t wd,
                      output cell_t rd, output int lat);
    int w;
    rd = '0; lat = 0; busy_rdy = 0; rsp_long = 1'b0; rdy_after = 1'b0;
    req_we = we; req_byte = byt; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = '1; req_wdata = 16'hDEAD; req_we = ~we; req_byte = ~byt;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin
      if (req_ready) busy_rdy++;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    if (req_ready) busy_rdy++;
    rd = rsp_rdata;
    @(negedge clk);
    rsp_long  = rsp_valid;
    rdy_after = req_ready;
  endtask

  cell_t rd;
  int    lat;
  int    n;

  initial begin
    // Reset state
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_ai", 32'(mem_ai), 32'd0);
    check("rst_mem_vi", 32'(mem_vi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check("ready_after_edge", 32'(req_ready), 32'd1);

    // 1 + 4: cell write / read, latencies and handshake shape
    xfer(1'b1, 1'b0, 17'h00010, 16'hA55A, rd, lat);
    check("cwr_lat", 32'(lat), 32'd3);
    check("cwr_busy_rdy", 32'(busy_rdy), 32'd0);
    check("cwr_rsp_once", 32'(rsp_long), 32'd0);
    check("cwr_rdy_after", 32'(rdy_after), 32'd1);
    check("ram_10", 32'(u_ram.mem[17'h00010]), 32'hA5);
    check("ram_11", 32'(u_ram.mem[17'h00011]), 32'h5A);
    xfer(1'b0, 1'b0, 17'h00010, 16'h0000, rd, lat);
    check("crd_data", 32'(rd), 32'hA55A);
    check("crd_lat", 32'(lat), 32'd5);
    check("crd_busy_rdy", 32'(busy_rdy), 32'd0);
    check("crd_rsp_once", 32'(rsp_long), 32'd0);
    check("crd_rdy_after", 32'(rdy_after), 32'd1);
    check("rdata_hold", 32'(rsp_rdata), 32'hA55A);

    // 2: byte accesses at odd address, then cell read spanning them
    xfer(1'b1, 1'b1, 17'h00021, 16'hFF3C, rd, lat);
    check("bwr_lat", 32'(lat), 32'd2);
    check("ram_21", 32'(u_ram.mem[17'h00021]), 32'h3C);
    check("rdata_hold_wr", 32'(rsp_rdata), 32'hA55A);
    xfer(1'b1, 1'b1, 17'h00020, 16'h00C3, rd, lat);
    xfer(1'b0, 1'b1, 17'h00021, 16'h0000, rd, lat);
    check("brd_data", 32'(rd), 32'h003C);
    check("brd_lat", 32'(lat), 32'd3);
    xfer(1'b0, 1'b0, 17'h00020, 16'h0000, rd, lat);
    check("crd_20", 32'(rd), 32'hC33C);

    // 3: address wrap
    xfer(1'b1, 1'b0, 17'h1FFFF, 16'h1234, rd, lat);
    check("ram_1ffff", 32'(u_ram.mem[17'h1FFFF]), 32'h12);
    check("ram_00000", 32'(u_ram.mem[17'h00000]), 32'h34);
    xfer(1'b0, 1'b0, 17'h1FFFF, 16'h0000, rd, lat);
    check("crd_wrap", 32'(rd), 32'h1234);

    // 5: req_valid held with changing operands during a write
    req_we = 1'b1; req_byte = 1'b0; req_addr = 17'h00040; req_wdata = 16'hBEEF; req_valid = 1'b1;
    check("b2b_ready0", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_addr = 17'h00050; req_wdata = 16'h1111;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rsp_seen", 32'(rsp_valid), 32'd1);
    check("b2b_busy_in_rsp", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_ready_after_rsp", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("b2b_accepted", 32'(req_ready), 32'd0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rsp2_seen", 32'(rsp_valid), 32'd1);
    check("ram_40", 32'(u_ram.mem[17'h00040]), 32'hBE);
    check("ram_41", 32'(u_ram.mem[17'h00041]), 32'hEF);
    check("ram_50", 32'(u_ram.mem[17'h00050]), 32'h11);
    check("ram_51", 32'(u_ram.mem[17'h00051]), 32'h11);
    @(negedge clk);

    // 6: reset during WR1 of a cell write
    req_we = 1'b1; req_byte = 1'b0; req_addr = 17'h00060; req_wdata = 16'h7788; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("wr1_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_ram_60", 32'(u_ram.mem[17'h00060]), 32'h77);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready0", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check("rel_ready1", 32'(req_ready), 32'd1);
    xfer(1'b0, 1'b0, 17'h00010, 16'h0000, rd, lat);
    check("post_rst_rd", 32'(rd), 32'hA55A);
    check("post_rst_lat", 32'(lat), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
